// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer slice.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT       = 2'd0,
    RUN        = 2'd1,
    WAIT_REDIR = 2'd2
  } pc_seq_state_e;

  localparam int unsigned PC_INC            = 4;
  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

endpackage

// File: rtl/pc_redirect_sel.sv
// Redirect source priority select (trap > mret > branch) with word alignment.
// Trap sources are present only when PCSEQ_TRAP_EN is defined.
module pc_redirect_sel #(
  parameter int unsigned Width = 32
) (
  input  logic             br_taken,
  input  logic [Width-1:0] br_target,
`ifdef PCSEQ_TRAP_EN
  input  logic             trap_req,
  input  logic             mret,
  input  logic [Width-1:0] trap_vec,
  input  logic [Width-1:0] mepc,
`endif
  output logic             redirect,
  output logic [Width-1:0] target
);

  localparam logic [Width-1:0] ALIGN_MASK = ~Width'(2'b11);

  logic [Width-1:0] raw_target;

  always_comb begin
`ifdef PCSEQ_TRAP_EN
    redirect = trap_req | mret | br_taken;
    if (trap_req)
      raw_target = trap_vec;
    else if (mret)
      raw_target = mepc;
    else
      raw_target = br_target;
`else
    redirect   = br_taken;
    raw_target = br_target;
`endif
    target = raw_target & ALIGN_MASK;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC sequencer driving the PC counter: boot vector, stall hold, and
// redirects held pending while imem is busy. Optional traps via PCSEQ_TRAP_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned      Width     = 32,
  parameter logic [Width-1:0] RESET_VEC = Width'(DEFAULT_RESET_VEC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] pc,
  input  logic             imem_ready,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [Width-1:0] br_target,
`ifdef PCSEQ_TRAP_EN
  input  logic             trap_req,
  input  logic             mret,
  input  logic [Width-1:0] trap_vec,
  input  logic [Width-1:0] mepc,
`endif
  output logic [Width-1:0] next_pc,
  output logic             pc_en,
  output logic             flush,
  output logic             fetch_valid
);

  pc_seq_state_e    state, state_nxt;
  logic [Width-1:0] pend_pc, pend_nxt;
  logic             redirect;
  logic [Width-1:0] target;
  logic [Width-1:0] pc_inc;

  assign pc_inc = pc + Width'(PC_INC);

  pc_redirect_sel #(
    .Width(Width)
  ) u_redirect_sel (
    .br_taken  (br_taken),
    .br_target (br_target),
`ifdef PCSEQ_TRAP_EN
    .trap_req  (trap_req),
    .mret      (mret),
    .trap_vec  (trap_vec),
    .mepc      (mepc),
`endif
    .redirect  (redirect),
    .target    (target)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= BOOT;
      pend_pc <= RESET_VEC;
    end else begin
      state   <= state_nxt;
      pend_pc <= pend_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend_pc;
    case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        if (redirect && !imem_ready) begin
          state_nxt = WAIT_REDIR;
          pend_nxt  = target;
        end
      end
      WAIT_REDIR: begin
        if (redirect)
          pend_nxt = target;
        if (imem_ready)
          state_nxt = RUN;
      end
      default: state_nxt = BOOT;
    endcase
  end

  // Outputs are gated by reset directly so they go quiet while reset is held.
  always_comb begin
    next_pc     = RESET_VEC;
    pc_en       = 1'b0;
    flush       = 1'b0;
    fetch_valid = 1'b0;
    if (reset) begin
      case (state)
        BOOT: begin
          next_pc = RESET_VEC;
          pc_en   = 1'b1;
        end
        RUN: begin
          if (redirect) begin
            next_pc = target;
            pc_en   = imem_ready;
            flush   = 1'b1;
          end else if (stall) begin
            next_pc = pc;
          end else begin
            next_pc = pc_inc;
            pc_en   = imem_ready;
          end
          fetch_valid = !redirect;
        end
        WAIT_REDIR: begin
          next_pc = redirect ? target : pend_pc;
          pc_en   = imem_ready;
          flush   = redirect;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter Width, default 32, PC width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset is asynchronous and active-low.
REQ-005 pc  input  Width  current PC from PCCounter output.
REQ-006 imem_ready  input  1  instruction memory accepts fetch this cycle.
REQ-007 stall  input  1  hazard unit requests PC hold.
REQ-008 br_taken  input  1  branch/jump resolved taken.
REQ-009 br_target  input  Width  branch/jump target.
REQ-010 trap_req, mret  input  1 each  trap entry / trap return (PCSEQ_TRAP_EN only).
REQ-011 trap_vec, mepc  input  Width each  trap vector / return address (PCSEQ_TRAP_EN only).
REQ-012 next_pc  output  Width  drives PCCounter PC1.
REQ-013 pc_en  output  1  drives PCCounter PCen.
REQ-014 flush  output  1  kill the wrong-path instruction in decode.
REQ-015 fetch_valid  output  1  instruction fetched this cycle is on the correct path.

Function
REQ-016 FSM SHALL have states BOOT, RUN and WAIT_REDIR; next_pc, pc_en, flush and fetch_valid are combinational from state, inputs and pend_pc.
REQ-017 BOOT: next_pc=RESET_VEC, pc_en=1, flush=0, fetch_valid=0; go to RUN on the next edge unconditionally.
REQ-018 Redirect priority SHALL be trap_req > mret > br_taken; redirect = any of these high; redirect target is trap_vec, mepc or br_target respectively.
REQ-019 RUN, redirect, imem_ready=1: next_pc=target, pc_en=1, flush=1; stay in RUN.
REQ-020 RUN, redirect, imem_ready=0: pc_en=0, flush=1; latch target into pend_pc; go to WAIT_REDIR.
REQ-021 RUN, no redirect, stall=1: pc_en=0, next_pc=pc, flush=0.
REQ-022 RUN, no redirect, stall=0: next_pc=pc+4, pc_en=imem_ready.
REQ-023 WAIT_REDIR: next_pc=pend_pc, pc_en=imem_ready, flush=0, fetch_valid=0; go to RUN when imem_ready=1; stall is ignored.
REQ-024 New redirect in WAIT_REDIR SHALL overwrite pend_pc and assert flush=1 that cycle; if imem_ready=1 in that cycle, next_pc equals the new target.
REQ-025 fetch_valid SHALL be 1 only in RUN with flush=0.
REQ-026 pc+4 SHALL wrap modulo 2^Width (pc=32'hFFFF_FFFC gives next_pc=0).
REQ-027 Bits [1:0] of every redirect target SHALL be forced to 0 before use and before latching.
REQ-028 Redirect-to-PC latency: target is visible on PCCounter PC one edge after the cycle in which pc_en=1 with that target.

Reset
REQ-029 reset low SHALL asynchronously force state=BOOT and pend_pc=RESET_VEC.
REQ-030 Outputs while reset is low: pc_en=0, flush=0, fetch_valid=0, next_pc=RESET_VEC.
REQ-031 reset asserted mid-WAIT_REDIR SHALL discard the pending redirect.

Configuration
REQ-032 Macro PCSEQ_TRAP_EN defined: trap_req, mret, trap_vec and mepc ports exist and take part in redirect priority.
REQ-033 PCSEQ_TRAP_EN undefined: those ports are absent and br_taken is the only redirect source.

Structure
REQ-034 Package pc_seq_pkg SHALL hold the state enum (BOOT, RUN, WAIT_REDIR), PC_INC=4 and the default RESET_VEC.
REQ-035 Sub-module pc_redirect_sel SHALL implement the combinational priority select plus alignment and output redirect and target.

Verification
REQ-036 Reset released, imem_ready=1 -> BOOT cycle with next_pc=0 and pc_en=1, then pc sequences 0, 4, 8.
REQ-037 pc=32'h100, stall=1 for 3 cycles -> pc_en=0 and pc stays 32'h100; stall=0 -> next_pc=32'h104.
REQ-038 pc=32'h200, br_taken=1, br_target=32'hAAAA_AAAB, imem_ready=1 -> flush=1, next_pc=32'hAAAA_AAA8, pc equals it after one edge.
REQ-039 br_taken=1 with imem_ready=0 for 2 cycles -> WAIT_REDIR, pc_en=0, fetch_valid=0; imem_ready=1 -> next_pc=latched target, back to RUN.
REQ-040 (PCSEQ_TRAP_EN) trap_req=1, br_taken=1, trap_vec=32'h8000_0000 in the same cycle -> next_pc=32'h8000_0000; mret with mepc=32'h204 -> next_pc=32'h204.
REQ-041 pc=32'hFFFF_FFFC, no stall -> next_pc=0; reset pulsed during WAIT_REDIR -> BOOT and next_pc=RESET_VEC.
